// File: rtl/elastic_pkg.sv
// Shared constants and types for the elastic fork slice.
// Provides the default payload width and a count-width helper.
package elastic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] token_t;

    // Bits needed to hold a fill level of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_fifo.sv
// Single-clock FIFO used per output channel of the elastic fork.
// Registered outputs only; no fall-through from push to dout.
module elastic_fifo
    import elastic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2,
    localparam int CW        = count_width(DEPTH),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointer increments wrap for free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/elastic_buffered_fork.sv
// Elastic fork: broadcasts each accepted token into per-channel FIFOs.
// Backpressure depends only on FIFO state, never on stop_output.
module elastic_buffered_fork
    import elastic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OUT_NUM    = 4,
    parameter int DEPTH      = 2,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         input_data,
    input  logic                          valid_input,
    output logic                          stop_input,
    output logic [OUT_NUM*DATA_WIDTH-1:0] output_data,
    output logic [OUT_NUM-1:0]            valid_output,
    input  logic [OUT_NUM-1:0]            stop_output,
    input  logic [OUT_NUM-1:0]            available_output,
    output logic                          switch_context,
    output logic [OUT_NUM*CW-1:0]         occupancy
);

    logic [OUT_NUM-1:0] full;
    logic [OUT_NUM-1:0] empty;
    logic [OUT_NUM-1:0] push;
    logic [OUT_NUM-1:0] pop;
    logic               accept;

    assign stop_input     = |(available_output & full);
    assign accept         = valid_input & ~stop_input;
    assign valid_output   = ~empty;
    assign switch_context = (&empty) & ~valid_input;

    // Disabled channels still drain; the enable gates writes only.
    for (genvar i = 0; i < OUT_NUM; i++) begin : g_ch
        assign push[i] = accept & available_output[i];
        assign pop[i]  = ~empty[i] & ~stop_output[i];

        elastic_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .din     (input_data),
            .dout    (output_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (occupancy[i*CW +: CW])
        );
    end

endmodule

// File: tb/tb_elastic_buffered_fork.sv
// Bench for elastic_buffered_fork against a queue-based channel model.
// Directed scenarios plus a randomized soak.
module tb_elastic_buffered_fork;

    localparam int DW    = 32;
    localparam int ON    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = ON + 2 + ON*CW + ON*DW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DW-1:0]     input_data;
    logic              valid_input;
    logic              stop_input;
    logic [ON*DW-1:0]  output_data;
    logic [ON-1:0]     valid_output;
    logic [ON-1:0]     stop_output;
    logic [ON-1:0]     available_output;
    logic              switch_context;
    logic [ON*CW-1:0]  occupancy;

    logic [DW-1:0] mq [ON][$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elastic_buffered_fork #(
        .DATA_WIDTH (DW),
        .OUT_NUM    (ON),
        .DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .input_data       (input_data),
        .valid_input      (valid_input),
        .stop_input       (stop_input),
        .output_data      (output_data),
        .valid_output     (valid_output),
        .stop_output      (stop_output),
        .available_output (available_output),
        .switch_context   (switch_context),
        .occupancy        (occupancy)
    );

    function automatic logic m_stop();
        for (int i = 0; i < ON; i++)
            if (available_output[i] && mq[i].size() == DEPTH)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [SW-1:0] exp_snap();
        logic [ON-1:0]    v;
        logic [ON*CW-1:0] oc;
        logic [ON*DW-1:0] d;
        logic             idle;
        v = '0; oc = '0; d = '0; idle = 1'b1;
        for (int i = 0; i < ON; i++) begin
            oc[i*CW +: CW] = CW'(mq[i].size());
            if (mq[i].size() != 0) begin
                v[i] = 1'b1;
                idle = 1'b0;
                d[i*DW +: DW] = mq[i][0];
            end
        end
        return {v, m_stop(), idle & ~valid_input, oc, d};
    endfunction

    function automatic logic [SW-1:0] dut_snap();
        logic [ON*DW-1:0] d;
        d = '0;
        for (int i = 0; i < ON; i++)
            if (valid_output[i])
                d[i*DW +: DW] = output_data[i*DW +: DW];
        return {valid_output, stop_input, switch_context,
                occupancy, d};
    endfunction

    // Called at the falling edge: advance the model over the next rise.
    task automatic tick();
        logic          acc;
        logic [ON-1:0] en;
        logic [ON-1:0] st;
        logic [DW-1:0] din;
        acc = valid_input & ~m_stop();
        en  = available_output;
        st  = stop_output;
        din = input_data;
        @(posedge clk);
        for (int i = 0; i < ON; i++) begin
            if (!st[i] && mq[i].size() > 0)
                void'(mq[i].pop_front());
            if (acc && en[i])
                mq[i].push_back(din);
        end
        #1;
    endtask

    task automatic flush_model();
        for (int i = 0; i < ON; i++) mq[i].delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid_input = 1'b0;
        input_data = '0;
        stop_output = '0;
        available_output = '1;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid_output, stop_input, switch_context, occupancy}
            !== {4'b0000, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset: got v=%b s=%b sw=%b occ=%h",
                     valid_output, stop_input, switch_context,
                     occupancy);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_broadcast();
        available_output = '1;
        stop_output = '0;
        for (int c = 0; c < 11; c++) begin
            valid_input = (c < 8);
            input_data = DW'(c + 1);
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL broadcast c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            checks++;
            if (stop_input !== 1'b0) begin
                errors++;
                $display("FAIL broadcast_stop c%0d: got %b want 0",
                         c, stop_input);
            end
            tick();
        end
    endtask

    task automatic test_slow_channel();
        int tk;
        tk = 1;
        available_output = '1;
        for (int c = 0; c < 20; c++) begin
            stop_output = (c < 5) ? 4'b0100 : 4'b0000;
            valid_input = (tk <= 5);
            input_data = DW'(tk);
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL slow c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            if (c == 3) begin
                checks++;
                if ({stop_input, valid_output, output_data[2*DW +: DW]}
                    !== {1'b1, 4'b0100, 32'd1}) begin
                    errors++;
                    $display("FAIL slow_stall: got s=%b v=%b d2=%h",
                             stop_input, valid_output,
                             output_data[2*DW +: DW]);
                end
            end
            if (valid_input && !m_stop()) tk++;
            tick();
        end
    endtask

    task automatic test_partial_enable();
        available_output = 4'b0101;
        stop_output = '0;
        for (int c = 0; c < 5; c++) begin
            valid_input = (c < 2);
            input_data = (c == 0) ? 32'hA : 32'hB;
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL partial c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            checks++;
            if ({valid_output[1], valid_output[3],
                 occupancy[CW +: CW], occupancy[3*CW +: CW]} !== '0) begin
                errors++;
                $display("FAIL partial_off c%0d: got v=%b occ=%h",
                         c, valid_output, occupancy);
            end
            tick();
        end
    endtask

    task automatic test_no_outputs();
        available_output = '0;
        stop_output = '0;
        for (int c = 0; c < 5; c++) begin
            valid_input = (c < 3);
            input_data = $urandom;
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL none c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            checks++;
            if ({stop_input, valid_output, switch_context}
                !== {1'b0, 4'b0000, ~valid_input}) begin
                errors++;
                $display("FAIL none_flags c%0d: got s=%b v=%b sw=%b",
                         c, stop_input, valid_output, switch_context);
            end
            tick();
        end
    endtask

    task automatic test_disable_buffered();
        available_output = '1;
        for (int c = 0; c < 8; c++) begin
            valid_input = (c < 2);
            input_data = DW'(32'h100 + c);
            stop_output = (c < 4) ? 4'b0010 : 4'b0000;
            if (c >= 3) available_output = 4'b1101;
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL disable c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({occupancy[CW +: CW], switch_context} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL disable_end: got occ1=%0d sw=%b want 0 1",
                     occupancy[CW +: CW], switch_context);
        end
    endtask

    task automatic test_reset_mid();
        available_output = '1;
        stop_output = '1;
        for (int c = 0; c < 3; c++) begin
            valid_input = 1'b1;
            input_data = DW'(32'h200 + c);
            @(negedge clk);
            tick();
        end
        valid_input = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        flush_model();
        checks++;
        if ({valid_output, stop_input, occupancy, switch_context}
            !== {4'b0000, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: got v=%b s=%b occ=%h sw=%b",
                     valid_output, stop_input, occupancy,
                     switch_context);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stop_output = '0;
        valid_input = 1'b1;
        input_data = 32'h55;
        @(negedge clk);
        tick();
        valid_input = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_output, output_data}
            !== {4'b1111, {4{32'h55}}}) begin
            errors++;
            $display("FAIL reset_first: got v=%b d=%h",
                     valid_output, output_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 25 == 0) available_output = ON'($urandom);
            valid_input = ($urandom_range(0, 3) != 0);
            input_data = $urandom;
            stop_output = ON'($urandom) & ON'($urandom);
            if (c >= 580) begin
                valid_input = 1'b0;
                stop_output = '0;
            end
            @(negedge clk);
            checks++;
            if (dut_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h",
                         c, dut_snap(), exp_snap());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_slow_channel();
        test_partial_enable();
        test_no_outputs();
        test_disable_buffered();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
